// File: rtl/branch_ctrl.sv
// branch_ctrl: sequences one ID-stage branch at a time.
// The controller accepts a request, waits for the forwarded operands it needs,
// drives the shared comparator for a single cycle, and returns taken/target
// through a valid/ready response. It also keeps saturating branch statistics.
module branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_sel,
    input  logic [31:0]      req_pc,
    input  logic [15:0]      req_offset,
    input  logic [31:0]      opnd_a,
    input  logic [31:0]      opnd_b,
    input  logic             opnd_a_vld,
    input  logic             opnd_b_vld,
    output logic [2:0]       comp_sel,
    output logic [31:0]      comp_a,
    output logic [31:0]      comp_b,
    input  logic             comp_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_taken,
    output logic [31:0]      resp_target,
    output logic             stall,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CMP  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_sel;
    logic [31:0]       r_pc;
    logic [15:0]       r_offset;
    logic [2:0]        r_comp_sel;
    logic [31:0]       r_comp_a;
    logic [31:0]       r_comp_b;
    logic              r_resp_valid;
    logic              r_resp_taken;
    logic [31:0]       r_resp_target;
    logic              r_req_ready;
    logic              r_stall;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic              w_need_b;
    logic              w_opnds_ok;
    logic [31:0]       w_offset_bytes;
    logic [31:0]       w_target_taken;
    logic [31:0]       w_target_fall;
    logic              w_handshake;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Only eq/ne compare two registers; every other selector tests rs alone.
    assign w_need_b       = (r_sel == 3'b100) || (r_sel == 3'b101);
    assign w_opnds_ok     = opnd_a_vld && (opnd_b_vld || !w_need_b);
    // Word offset sign-extended and scaled to bytes.
    assign w_offset_bytes = {{14{r_offset[15]}}, r_offset, 2'b00};
    // Both targets are relative to the delay slot (pc + 4).
    assign w_target_taken = r_pc + 32'd4 + w_offset_bytes;
    assign w_target_fall  = r_pc + 32'd8;
    assign w_handshake    = r_resp_valid && resp_ready;

    // Main sequencing FSM with all control/data outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_sel         <= 3'b000;
            r_pc          <= 32'd0;
            r_offset      <= 16'd0;
            r_comp_sel    <= 3'b000;
            r_comp_a      <= 32'd0;
            r_comp_b      <= 32'd0;
            r_resp_valid  <= 1'b0;
            r_resp_taken  <= 1'b0;
            r_resp_target <= 32'd0;
            r_req_ready   <= 1'b1;
            r_stall       <= 1'b0;
        end else if (flush) begin
            // Abort whatever is in flight; no response is ever produced for it.
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_stall      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_sel       <= req_sel;
                        r_pc        <= req_pc;
                        r_offset    <= req_offset;
                        r_req_ready <= 1'b0;
                        r_stall     <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Operands are captured straight into the comparator drive
                    // registers, so they stay put after the compare cycle.
                    if (w_opnds_ok) begin
                        r_comp_sel <= r_sel;
                        r_comp_a   <= opnd_a;
                        r_comp_b   <= w_need_b ? opnd_b : 32'd0;
                        r_state    <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_resp_taken  <= comp_result;
                    r_resp_target <= comp_result ? w_target_taken : w_target_fall;
                    r_resp_valid  <= 1'b1;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_stall      <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_stall      <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // Statistics: count accepted responses, including one that meets a flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_branch_cnt <= {CNT_W{1'b0}};
            r_taken_cnt  <= {CNT_W{1'b0}};
        end else if (w_handshake) begin
            r_branch_cnt <= sat_inc(r_branch_cnt);
            if (r_resp_taken) begin
                r_taken_cnt <= sat_inc(r_taken_cnt);
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign stall       = r_stall;
    assign comp_sel    = r_comp_sel;
    assign comp_a      = r_comp_a;
    assign comp_b      = r_comp_b;
    assign resp_valid  = r_resp_valid;
    assign resp_taken  = r_resp_taken;
    assign resp_target = r_resp_target;
    assign branch_cnt  = r_branch_cnt;
    assign taken_cnt   = r_taken_cnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a driver issues branches and queues the
// expected resolution, an independent monitor checks every response.
module tb_branch_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n, flush, req_valid, req_ready;
    logic [2:0]       req_sel;
    logic [31:0]      req_pc;
    logic [15:0]      req_offset;
    logic [31:0]      opnd_a, opnd_b;
    logic             opnd_a_vld, opnd_b_vld;
    logic [2:0]       comp_sel;
    logic [31:0]      comp_a, comp_b;
    logic             comp_result;
    logic             resp_valid, resp_ready, resp_taken;
    logic [31:0]      resp_target;
    logic             stall;
    logic [CNT_W-1:0] branch_cnt, taken_cnt;

    branch_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_pc(req_pc), .req_offset(req_offset),
        .opnd_a(opnd_a), .opnd_b(opnd_b),
        .opnd_a_vld(opnd_a_vld), .opnd_b_vld(opnd_b_vld),
        .comp_sel(comp_sel), .comp_a(comp_a), .comp_b(comp_b),
        .comp_result(comp_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_taken(resp_taken), .resp_target(resp_target),
        .stall(stall), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    // Branch condition as the ISA defines it for each selector.
    function automatic logic branch_rule(input logic [2:0] sel, input logic [31:0] a,
                                         input logic [31:0] b);
        case (sel)
            3'b000:  return $signed(a) < 0;
            3'b001:  return $signed(a) >= 0;
            3'b100:  return a == b;
            3'b101:  return a != b;
            3'b110:  return $signed(a) <= 0;
            default: return $signed(a) > 0;
        endcase
    endfunction

    // Stand-in for the shared comparator.
    assign comp_result = branch_rule(comp_sel, comp_a, comp_b);

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [15:0] off,
                                            input logic tk);
        int soff;
        soff = int'($signed(off));
        return tk ? (pc + 32'd4 + 32'(soff * 4)) : (pc + 32'd8);
    endfunction

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        taken;
        logic [31:0] target;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    logic [CNT_W-1:0] m_branch = '0;
    logic [CNT_W-1:0] m_taken = '0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares DUT responses and counters against the scoreboard.
    initial begin
        exp_t cur;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("branch_cnt", 64'(branch_cnt), 64'(m_branch));
                chk("taken_cnt", 64'(taken_cnt), 64'(m_taken));
                if (sb.size() == 0) begin
                    chk("spurious_resp", 64'(resp_valid), 64'd0);
                end else if (resp_valid) begin
                    cur = sb[0];
                    if (!prev_valid) chk("latency", 64'(cyc - cur.acc_cyc), 64'(cur.lat));
                    chk("resp_taken", 64'(resp_taken), 64'(cur.taken));
                    chk("resp_target", 64'(resp_target), 64'(cur.target));
                    chk("comp_sel", 64'(comp_sel), 64'(cur.sel));
                    chk("comp_a", 64'(comp_a), 64'(cur.a));
                    chk("comp_b", 64'(comp_b), 64'(cur.b));
                    chk("req_ready_busy", 64'(req_ready), 64'd0);
                    chk("stall_resp", 64'(stall), 64'd1);
                    if (resp_ready) begin
                        void'(sb.pop_front());
                        m_branch = (m_branch == CNT_MAX) ? m_branch : m_branch + 1'b1;
                        if (cur.taken) m_taken = (m_taken == CNT_MAX) ? m_taken : m_taken + 1'b1;
                    end
                end
                prev_valid = resp_valid;
            end
        end
    end

    // One full branch: accept, feed operands after the given delays, then
    // hold off resp_ready for rdy_dly cycles before the handshake.
    task automatic run_branch(input logic [2:0] sel, input logic [31:0] pc,
                              input logic [15:0] off, input logic [31:0] a,
                              input logic [31:0] b, input int dly_a, input int dly_b,
                              input int rdy_dly, input bit flush_at_hs);
        exp_t e;
        bit   need_b;
        int   d;
        bit   got;
        need_b = (sel == 3'b100) || (sel == 3'b101);
        d = dly_a;
        if (need_b && dly_b > d) d = dly_b;
        e.sel = sel;
        e.a = a;
        e.b = need_b ? b : 32'd0;
        e.taken = branch_rule(sel, a, b);
        e.target = next_pc(pc, off, e.taken);
        // resp_valid rises on the second edge after acceptance plus one edge per
        // cycle of missing operand validity.
        e.lat = 2 + d;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_sel = sel; req_pc = pc; req_offset = off;
        opnd_a_vld = 1'b0; opnd_b_vld = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_sel = 3'($urandom_range(0, 7)); req_pc = $urandom; req_offset = 16'($urandom);
        e.acc_cyc = cyc;
        sb.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            opnd_a_vld = (k >= dly_a);
            opnd_b_vld = (k >= dly_b);
            opnd_a = opnd_a_vld ? a : $urandom;
            opnd_b = opnd_b_vld ? b : $urandom;
            @(posedge clk); #1;
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            chk("stall_wait", 64'({stall, req_ready}), 64'b10);
        end
        opnd_a_vld = 1'b0; opnd_b_vld = 1'b0; opnd_a = $urandom; opnd_b = $urandom;
        if (!got) begin
            chk("resp_timeout", 64'(resp_valid), 64'd1);
            void'(sb.pop_front());
        end else begin
            for (int j = 0; j < rdy_dly; j++) begin
                @(posedge clk); #1;
            end
            resp_ready = 1'b1;
            flush = flush_at_hs;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            flush = 1'b0;
            chk("idle_after_hs", 64'({resp_valid, req_ready, stall}), 64'b010);
        end
    endtask

    // Flush in WAIT (mode 0) or flush together with req_valid in IDLE (mode 1).
    task automatic run_flush(input int mode);
        req_valid = 1'b1; req_sel = 3'b100; req_pc = 32'h0000_4000; req_offset = 16'h0008;
        opnd_a_vld = 1'b0; opnd_b_vld = 1'b0;
        if (mode == 1) flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (mode == 0) begin
            chk("flush_accepted", 64'(stall), 64'd1);
            @(posedge clk); #1;
            flush = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b0;
        chk("flush_idle", 64'({req_ready, stall}), 64'b10);
        opnd_a = 32'd9; opnd_b = 32'd9; opnd_a_vld = 1'b1; opnd_b_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("flush_no_resp", 64'({resp_valid, stall}), 64'b00);
        end
        opnd_a_vld = 1'b0; opnd_b_vld = 1'b0;
    endtask

    initial begin
        logic [2:0]  s;
        logic [31:0] a, b;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b1; req_sel = 3'b100;
        req_pc = 32'h1234; req_offset = 16'h1; opnd_a = 32'd1; opnd_b = 32'd1;
        opnd_a_vld = 1'b1; opnd_b_vld = 1'b1; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 64'({req_ready, stall, resp_valid, resp_taken}), 64'b1000);
        chk("rst_target", 64'(resp_target), 64'd0);
        chk("rst_comp", 64'({comp_sel, comp_a, comp_b}), 64'd0);
        chk("rst_cnt", 64'({branch_cnt, taken_cnt}), 64'd0);
        rst_n = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        opnd_a_vld = 1'b0; opnd_b_vld = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // beq taken: 0x3000 + 4 + 16
        run_branch(3'b100, 32'h0000_3000, 16'h0004, 32'd5, 32'd5, 0, 0, 0, 1'b0);
        // bne with equal operands, rt late by four cycles
        run_branch(3'b101, 32'h0000_3100, 16'h0010, 32'd7, 32'd7, 0, 4, 0, 1'b0);
        // bltz never waits for rt; offset -1 lands back on the branch
        run_branch(3'b000, 32'h0000_3000, 16'hFFFF, 32'h8000_0000, 32'h1234_5678,
                   0, 1000, 0, 1'b0);
        run_flush(0);
        run_flush(1);
        // response backpressure
        run_branch(3'b110, 32'h0000_5000, 16'h0020, 32'd0, 32'd3, 2, 0, 5, 1'b0);
        // flush coinciding with the handshake still counts it
        run_branch(3'b111, 32'h0000_6000, 16'h8000, 32'd1, 32'd0, 1, 3, 2, 1'b1);

        for (int n = 0; n < 120; n++) begin
            s = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       a = 32'd0;
                1:       a = 32'h8000_0000 | $urandom;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            run_branch(s, {$urandom, 2'b00}, 16'($urandom), a, b,
                       $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), 1'b0);
        end

        // 2^CNT_W + 2 taken branches drive both counters into saturation
        for (int n = 0; n < (1 << CNT_W) + 2; n++) begin
            run_branch(3'b100, 32'h0000_7000, 16'h0001, 32'd3, 32'd3, 0, 0, 0, 1'b0);
        end
        @(negedge clk);
        chk("branch_cnt_sat", 64'(branch_cnt), 64'(CNT_MAX));
        chk("taken_cnt_sat", 64'(taken_cnt), 64'(CNT_MAX));
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Sequencing controller for the ID-stage branch comparator in the pipelined MIPS core. It accepts one branch request at a time from decode and waits until the forwarded operand(s) it needs are valid. It then drives the shared comparator for one cycle and returns a taken flag and next-PC target through a valid/ready response. It also maintains saturating branch/taken statistics counters for the performance registers.

## Interface

Parameters:
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  abort any in-flight branch, from exception/redirect logic
- req_valid  in  1  decode presents a branch
- req_ready  out  1  controller can accept a request
- req_sel  in  3  comparator selector: 000 lt0, 001 ge0, 100 eq, 101 ne, 110 le0, 111/010/011 gt0
- req_pc  in  32  PC of the branch instruction
- req_offset  in  16  raw immediate (word offset)
- opnd_a, opnd_b  in  32 each  forwarded rs/rt values
- opnd_a_vld, opnd_b_vld  in  1 each  forwarded value is final (no pending producer)
- comp_sel  out  3  to comparator CompSel
- comp_a, comp_b  out  32 each  to comparator A/B
- comp_result  in  1  comparator BranchComp (combinational from comp_*)
- resp_valid  out  1  resolution available
- resp_ready  in  1  fetch accepts resolution
- resp_taken  out  1  branch taken
- resp_target  out  32  next fetch PC after the delay slot
- stall  out  1  decode must hold
- branch_cnt, taken_cnt  out  CNT_W each  saturating statistics

## Operation

- States: IDLE, WAIT, CMP, RESP.
- IDLE:
  - req_ready=1, stall=0.
  - On req_valid&&!flush, latch sel, pc and offset, then go to WAIT.
- Operand need:
  - sel 100/101 need A and B.
  - All other selectors need A only; B is latched as 0.
- WAIT:
  - stall=1.
  - Every cycle, once all needed opnd_*_vld are high, latch opnd_a/opnd_b into internal registers and go to CMP.
  - Otherwise remain in WAIT; there is no timeout.
- CMP:
  - comp_sel/comp_a/comp_b are driven from the latched registers.
  - Capture comp_result into the taken register at the end of the cycle, then go to RESP.
- RESP:
  - resp_valid=1; resp_taken and resp_target are stable until the handshake.
  - On resp_ready, go to IDLE.
- Target arithmetic, all mod 2^32, wrap ignored:
  - Taken: pc + 4 + (sign_extend(offset) << 2).
  - Not taken: pc + 8.
- Counters update only on the response handshake (resp_valid&&resp_ready):
  - branch_cnt += 1.
  - taken_cnt += resp_taken.
  - Both hold at all-ones (saturate, no wrap).
- flush:
  - In any state, the next state is IDLE.
  - No response is produced and the counters are unchanged.
  - In IDLE, flush blocks acceptance even when req_valid=1.
  - In RESP, a flush coinciding with resp_ready still counts the handshake.
- stall = (state != IDLE).
- comp_* hold their last driven values outside CMP.

## Timing

- Reset (rst_n=0 at an edge):
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_taken=0, resp_target=0.
  - comp_sel=000, comp_a=0, comp_b=0.
  - Both counters=0, stall=0.
- rst_n has priority over flush and over every handshake; reset mid-branch discards it without counting.
- Minimum latency: accept at edge T, operands valid in cycle T+1, comp_* valid during T+2, resp_valid high from T+3.
- Each cycle of missing operand validity adds exactly one cycle.
- No back-to-back acceptance: after the response handshake at edge R, req_ready=1 during cycle R+1.
- resp_* must not change while resp_valid=1 && !resp_ready.

## Test plan

- Reset, then beq: sel=100, pc=0x00003000, offset=0x0004, A=B=5, both valid immediately -> resp_valid 3 cycles after accept, taken=1, target=0x00003014, branch_cnt=1, taken_cnt=1.
- bne with A=B, opnd_b_vld low for 4 cycles -> stall high throughout, comp driven only after B valid, taken=0, target=pc+8, latency 3+4 cycles.
- bltz: sel=000, A=0x80000000, opnd_b_vld=0 -> does not wait for B, taken=1; offset=0xFFFF with pc=0x00003000 -> target=0x00003000.
- Flush while in WAIT, and flush concurrent with req_valid in IDLE -> IDLE next cycle, no resp_valid, counters unchanged.
- Response backpressure: resp_ready low 5 cycles -> resp_* stable and req_ready=0 throughout; counters increment once on the handshake.
- Preload counters near saturation, issue 2^CNT_W+2 taken branches -> both counters stick at 0xFFFF.
